// File: rtl/text_vram.sv
// Character-cell VRAM with host write port, hardware clear, row scroll and a 2-cycle render fetch.
// Optional cursor overlay is compiled in with `define TEXT_VRAM_CURSOR_EN.
module text_vram #(
    parameter int         COLS        = 80,
    parameter int         ROWS        = 30,
    parameter int         BIT_WIDTH   = 12,
    parameter int         BIT_HEIGHT  = 11,
    parameter int         FONT_WIDTH  = 8,
    parameter int         FONT_HEIGHT = 16,
    parameter logic [7:0] CLEAR_CHAR  = 8'h20,
    parameter logic [7:0] CLEAR_ATTR  = 8'h07
) (
    input  logic                      clk_pixel,
    input  logic                      rst_n,
    input  logic [BIT_WIDTH-1:0]      cx,
    input  logic [BIT_HEIGHT-1:0]     cy,
    output logic [7:0]                codepoint,
    output logic [7:0]                charattr,
    output logic [BIT_WIDTH-1:0]      cx_d,
    output logic [BIT_HEIGHT-1:0]     cy_d,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [$clog2(COLS)-1:0]   wr_col,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [15:0]               wr_data,
    input  logic                      clr_req,
    output logic                      busy,
`ifdef TEXT_VRAM_CURSOR_EN
    input  logic [$clog2(COLS)-1:0]   cursor_col,
    input  logic [$clog2(ROWS)-1:0]   cursor_row,
`endif
    input  logic [$clog2(ROWS)-1:0]   scroll
);

    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int DEPTH  = COLS * ROWS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int FW_SH  = $clog2(FONT_WIDTH);
    localparam int FH_SH  = $clog2(FONT_HEIGHT);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   k_q, k_d;

    logic [15:0]         mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [15:0]         mem_wdata;

    logic                wr_in_range;
    logic [ADDR_W-1:0]   wr_addr;

    logic [BIT_WIDTH-1:0]  col_full;
    logic [BIT_HEIGHT-1:0] row_full;
    logic                  in_range;
    logic [ROW_W:0]        row_sum;
    logic [ROW_W:0]        prow;
    logic [ADDR_W-1:0]     rd_addr;

    logic [ADDR_W-1:0]     addr_p1_q;
    logic                  rng_p1_q;
    logic [BIT_WIDTH-1:0]  cx_p1_q;
    logic [BIT_HEIGHT-1:0] cy_p1_q;

    logic [7:0]            code_p2_q;
    logic [7:0]            attr_p2_q;
    logic [BIT_WIDTH-1:0]  cx_p2_q;
    logic [BIT_HEIGHT-1:0] cy_p2_q;

    function automatic logic [7:0] swap_nibbles(input logic [7:0] a);
        return {a[3:0], a[7:4]};
    endfunction

    // Clear sequencer: one cell per cycle, host port locked out while it runs.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            ST_CLEAR: begin
                if (k_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    k_d     = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    assign busy     = (state_q == ST_CLEAR);
    assign wr_ready = (state_q == ST_IDLE);

    assign wr_in_range = ({1'b0, wr_col} < (COL_W + 1)'(COLS)) &&
                         ({1'b0, wr_row} < (ROW_W + 1)'(ROWS));
    assign wr_addr     = ADDR_W'(wr_row) * ADDR_W'(COLS) + ADDR_W'(wr_col);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = k_q;
            mem_wdata = {CLEAR_ATTR, CLEAR_CHAR};
        end else if (wr_valid && wr_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Pixel -> cell: out-of-range lookups read address 0 and are blanked later.
    assign col_full = cx >> FW_SH;
    assign row_full = cy >> FH_SH;
    assign in_range = (col_full < BIT_WIDTH'(COLS)) && (row_full < BIT_HEIGHT'(ROWS));
    assign row_sum  = (ROW_W + 1)'(row_full[ROW_W-1:0]) + (ROW_W + 1)'(scroll);
    assign prow     = (row_sum >= (ROW_W + 1)'(ROWS)) ? row_sum - (ROW_W + 1)'(ROWS) : row_sum;
    assign rd_addr  = in_range ? ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col_full[COL_W-1:0])
                               : '0;

`ifdef TEXT_VRAM_CURSOR_EN
    logic [4:0] frame_q;
    logic       cur_hit;
    logic       cur_p1_q;

    assign cur_hit = in_range && frame_q[4] &&
                     (col_full[COL_W-1:0] == cursor_col) &&
                     (row_full[ROW_W-1:0] == cursor_row);

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            frame_q  <= '0;
            cur_p1_q <= 1'b0;
        end else begin
            if (cx == '0 && cy == '0) begin
                frame_q <= frame_q + 5'd1;
            end
            cur_p1_q <= cur_hit;
        end
    end
`endif

    // Stage 1: cell address, range flag and coordinates
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            addr_p1_q <= '0;
            rng_p1_q  <= 1'b0;
            cx_p1_q   <= '0;
            cy_p1_q   <= '0;
        end else begin
            addr_p1_q <= rd_addr;
            rng_p1_q  <= in_range;
            cx_p1_q   <= cx;
            cy_p1_q   <= cy;
        end
    end

    // Stage 2: RAM read (read-first against the write port) and blanking
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            code_p2_q <= '0;
            attr_p2_q <= '0;
            cx_p2_q   <= '0;
            cy_p2_q   <= '0;
        end else begin
            if (rng_p1_q) begin
                code_p2_q <= mem[addr_p1_q][7:0];
`ifdef TEXT_VRAM_CURSOR_EN
                attr_p2_q <= cur_p1_q ? swap_nibbles(mem[addr_p1_q][15:8])
                                      : mem[addr_p1_q][15:8];
`else
                attr_p2_q <= mem[addr_p1_q][15:8];
`endif
            end else begin
                code_p2_q <= '0;
                attr_p2_q <= '0;
            end
            cx_p2_q <= cx_p1_q;
            cy_p2_q <= cy_p1_q;
        end
    end

    assign codepoint = code_p2_q;
    assign charattr  = attr_p2_q;
    assign cx_d      = cx_p2_q;
    assign cy_d      = cy_p2_q;

`ifndef TEXT_VRAM_CURSOR_EN
    logic unused_swap;
    assign unused_swap = ^swap_nibbles(8'h00);
`endif

endmodule

// File: tb/tb_text_vram.sv
// Scoreboard bench for text_vram: lookups push expected cells, a negedge monitor pops and compares.
module tb_text_vram;

    logic        clk_pixel = 1'b0;
    logic        rst_n;
    logic [11:0] cx;
    logic [10:0] cy;
    logic [7:0]  codepoint;
    logic [7:0]  charattr;
    logic [11:0] cx_d;
    logic [10:0] cy_d;
    logic        wr_valid;
    logic        wr_ready;
    logic [6:0]  wr_col;
    logic [4:0]  wr_row;
    logic [15:0] wr_data;
    logic        clr_req;
    logic        busy;
    logic [4:0]  scroll;
`ifdef TEXT_VRAM_CURSOR_EN
    logic [6:0]  cursor_col = 7'd0;
    logic [4:0]  cursor_row = 5'd0;
`endif

    text_vram dut (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .cx        (cx),
        .cy        (cy),
        .codepoint (codepoint),
        .charattr  (charattr),
        .cx_d      (cx_d),
        .cy_d      (cy_d),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_col    (wr_col),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .clr_req   (clr_req),
        .busy      (busy),
`ifdef TEXT_VRAM_CURSOR_EN
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
`endif
        .scroll    (scroll)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        int          due;
        logic [7:0]  code;
        logic [7:0]  attr;
        logic [11:0] x;
        logic [10:0] y;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk_pixel) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares the DUT output against the scoreboard entry due this cycle.
    always @(negedge clk_pixel) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q[0];
            if (e.due < cyc) begin
                void'(q.pop_front());
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL %s: output slot missed at cycle %0d", e.name, e.due);
            end else if (e.due == cyc) begin
                void'(q.pop_front());
                checks = checks + 1;
                if ({codepoint, charattr, cx_d, cy_d} !== {e.code, e.attr, e.x, e.y}) begin
                    failures = failures + 1;
                    $display("FAIL %s: got code=%h attr=%h cx_d=%0d cy_d=%0d expected code=%h attr=%h cx_d=%0d cy_d=%0d",
                             e.name, codepoint, charattr, cx_d, cy_d, e.code, e.attr, e.x, e.y);
                end
            end
        end
    end

    task automatic look(input int x, input int y, input int scr,
                        input logic [7:0] code, input logic [7:0] attr, input string name);
        exp_t e;
        @(posedge clk_pixel);
        #1;
        cx     = 12'(x);
        cy     = 11'(y);
        scroll = 5'(scr);
        e.due  = cyc + 2;
        e.code = code;
        e.attr = attr;
        e.x    = 12'(x);
        e.y    = 11'(y);
        e.name = name;
        q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(negedge clk_pixel);
            n++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic host_write(input int col, input int row, input logic [15:0] data);
        int n;
        @(posedge clk_pixel);
        #1;
        wr_valid = 1'b1;
        wr_col   = 7'(col);
        wr_row   = 5'(row);
        wr_data  = data;
        n = 0;
        forever begin
            @(negedge clk_pixel);
            if (wr_ready || n >= 3000) break;
            n++;
        end
        if (!wr_ready) chk("write_ready_timeout", 32'(wr_ready), 32'd1);
        @(posedge clk_pixel);
        #1;
        wr_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        cx       = '0;
        cy       = '0;
        wr_valid = 1'b0;
        wr_col   = '0;
        wr_row   = '0;
        wr_data  = '0;
        clr_req  = 1'b0;
        scroll   = '0;

        repeat (3) @(posedge clk_pixel);
        @(negedge clk_pixel);
        chk("reset_codepoint", 32'(codepoint), 32'h0);
        chk("reset_charattr", 32'(charattr), 32'h0);
        chk("reset_cx_d", 32'(cx_d), 32'h0);
        chk("reset_cy_d", 32'(cy_d), 32'h0);
        chk("reset_busy", 32'(busy), 32'h1);
        chk("reset_wr_ready", 32'(wr_ready), 32'h0);

        @(posedge clk_pixel);
        #1;
        rst_n = 1'b1;
        n = 0;
        forever begin
            @(negedge clk_pixel);
            if (!busy || n >= 3000) break;
            n++;
        end
        chk("busy_after_reset_cycles", 32'(n), 32'd2400);
        chk("wr_ready_after_clear", 32'(wr_ready), 32'h1);

        // Every cell holds the clear pattern.
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                look(c * 8 + (c % 8), r * 16 + (r % 16), 0, 8'h20, 8'h07, "scan_clear");
        drain();

        host_write(3, 2, 16'h1F41);
        for (int y = 32; y < 48; y++)
            for (int x = 24; x < 32; x++)
                look(x, y, 0, 8'h41, 8'h1F, "cell_3_2");
        look(32, 32, 0, 8'h20, 8'h07, "cell_4_2_neighbor");
        look(23, 47, 0, 8'h20, 8'h07, "cell_2_2_neighbor");
        drain();

        host_write(0, 0, 16'h2A42);
        host_write(0, 29, 16'h3343);
        look(0, 16, 29, 8'h42, 8'h2A, "scroll29_lrow1");
        look(7, 0, 29, 8'h43, 8'h33, "scroll29_lrow0");
        look(24, 48, 29, 8'h41, 8'h1F, "scroll29_lrow3_wrap");
        look(0, 0, 0, 8'h42, 8'h2A, "scroll0_row0_next_pixel");
        look(0, 464, 0, 8'h43, 8'h33, "scroll0_row29");
        drain();

        look(640, 0, 0, 8'h00, 8'h00, "oob_col80");
        look(0, 480, 0, 8'h00, 8'h00, "oob_row30");
        look(4095, 2047, 0, 8'h00, 8'h00, "oob_max");
        look(639, 479, 0, 8'h20, 8'h07, "last_cell_in_range");
        drain();

        host_write(80, 0, 16'hFFFF);
        look(0, 16, 0, 8'h20, 8'h07, "oob_write_discarded");
        look(639, 0, 0, 8'h20, 8'h07, "oob_write_row0_last");
        drain();

        // Write accepted alongside clr_req, then a second write held off by the clear.
        @(posedge clk_pixel);
        #1;
        wr_valid = 1'b1;
        wr_col   = 7'd10;
        wr_row   = 5'd10;
        wr_data  = 16'h1122;
        clr_req  = 1'b1;
        @(negedge clk_pixel);
        chk("wr_ready_with_clr", 32'(wr_ready), 32'h1);
        @(posedge clk_pixel);
        #1;
        clr_req = 1'b0;
        wr_col  = 7'd11;
        wr_row  = 5'd11;
        wr_data = 16'h5A4E;
        n = 0;
        forever begin
            @(negedge clk_pixel);
            if (wr_ready || n >= 3000) break;
            n++;
        end
        chk("wr_ready_low_cycles", 32'(n), 32'd2400);
        chk("busy_low_after_clr", 32'(busy), 32'h0);
        @(posedge clk_pixel);
        #1;
        wr_valid = 1'b0;
        look(80, 160, 0, 8'h20, 8'h07, "clr_overwrites_write");
        look(88, 176, 0, 8'h4E, 8'h5A, "held_write_completes");
        look(24, 32, 0, 8'h20, 8'h07, "clr_wipes_cell_3_2");
        look(0, 0, 0, 8'h20, 8'h07, "clr_wipes_cell_0_0");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
